// File: rtl/axis_pkt_fifo_if.sv
// AXI4-Stream beat bundle for one direction of transfer plus its ready.
// master drives the beat, slave drives tready.
interface axis_pkt_fifo_if #(
  parameter int DATA_W = 32,
  parameter int KEEP_W = DATA_W / 8,
  parameter int USER_W = 1
);
  logic              tvalid;
  logic              tready;
  logic [DATA_W-1:0] tdata;
  logic [KEEP_W-1:0] tkeep;
  logic              tlast;
  logic [USER_W-1:0] tuser;

  modport master (output tvalid, tdata, tkeep, tlast, tuser, input tready);
  modport slave  (input tvalid, tdata, tkeep, tlast, tuser, output tready);
endinterface

// File: rtl/axis_pkt_fifo.sv
// Single-clock AXIS FIFO: beat mode (1-cycle latency) or store-and-forward packet mode (valid the cycle after tlast).
// Backpressure at full; a partial packet filling the whole FIFO is discarded instead, as is an errored packet.
module axis_pkt_fifo #(
  parameter int DATA_W            = 32,
  parameter int KEEP_W            = DATA_W / 8,
  parameter int USER_W            = 1,
  parameter int DEPTH             = 1024,
  parameter int PACKET_MODE       = 0,
  parameter int DROP_ERR          = 0,
  parameter int PROG_FULL_THRESH  = DEPTH - 8,
  parameter int PROG_EMPTY_THRESH = 8,
  parameter int CNT_W             = $clog2(DEPTH) + 1
) (
  input  logic             aclk,
  input  logic             areset,
  axis_pkt_fifo_if.slave   s_axis,
  axis_pkt_fifo_if.master  m_axis,
  output logic [CNT_W-1:0] wr_count,
  output logic [CNT_W-1:0] rd_count,
  output logic             prog_full,
  output logic             prog_empty,
  output logic             pkt_drop
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] PF_C    = CNT_W'(PROG_FULL_THRESH);
  localparam logic [CNT_W-1:0] PE_C    = CNT_W'(PROG_EMPTY_THRESH);

  typedef struct packed {
    logic [DATA_W-1:0] tdata;
    logic [KEEP_W-1:0] tkeep;
    logic              tlast;
    logic [USER_W-1:0] tuser;
  } beat_t;

  typedef enum logic {PASS, DROP} state_t;

  beat_t            mem [DEPTH];
  beat_t            wr_beat;
  beat_t            rd_beat;
  logic [CNT_W-1:0] wr_ptr;
  logic [CNT_W-1:0] cm_ptr;
  logic [CNT_W-1:0] rd_ptr;
  state_t           state;
  logic             rdy_en;
  logic             full;
  logic             avail;
  logic             overflow;
  logic             wr_acc;
  logic             rd_acc;
  logic             err_last;
  logic             store;

  assign wr_count   = wr_ptr - rd_ptr;
  assign rd_count   = cm_ptr - rd_ptr;
  assign full       = (wr_count == DEPTH_C);
  assign avail      = (rd_count != '0);
  assign prog_full  = (wr_count >= PF_C);
  assign prog_empty = (rd_count <= PE_C);

  assign wr_beat = {s_axis.tdata, s_axis.tkeep, s_axis.tlast, s_axis.tuser};

  // Overflow only when nothing committed remains to drain: the packet can never fit.
  always_comb begin
    overflow      = 1'b0;
    s_axis.tready = 1'b0;
    if (PACKET_MODE == 0) begin
      s_axis.tready = rdy_en & ~full;
    end else if (state == DROP) begin
      s_axis.tready = rdy_en;
    end else begin
      overflow      = full & ~avail;
      s_axis.tready = rdy_en & (~full | overflow);
    end
  end

  assign wr_acc   = s_axis.tvalid & s_axis.tready;
  assign err_last = (PACKET_MODE != 0) && (DROP_ERR != 0) && wr_beat.tlast && wr_beat.tuser[0];
  assign store    = wr_acc && (state == PASS) && !overflow && !err_last;
  assign rd_acc   = avail & m_axis.tready;

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      wr_ptr   <= '0;
      cm_ptr   <= '0;
      rd_ptr   <= '0;
      state    <= PASS;
      rdy_en   <= 1'b0;
      pkt_drop <= 1'b0;
    end else begin
      rdy_en   <= 1'b1;
      pkt_drop <= 1'b0;
      if (rd_acc) begin
        rd_ptr <= rd_ptr + ONE;
      end
      if (store) begin
        wr_ptr <= wr_ptr + ONE;
        if ((PACKET_MODE == 0) || wr_beat.tlast) begin
          cm_ptr <= wr_ptr + ONE;
        end
      end else if (wr_acc && (state == PASS)) begin
        // Overflow or errored tlast: rewind to the last commit, dropping the partial packet.
        wr_ptr   <= cm_ptr;
        pkt_drop <= 1'b1;
        if (overflow && !wr_beat.tlast) begin
          state <= DROP;
        end
      end else if (wr_acc && wr_beat.tlast) begin
        state <= PASS;
      end
    end
  end

  always_ff @(posedge aclk) begin
    if (store) begin
      mem[wr_ptr[AW-1:0]] <= wr_beat;
    end
  end

  assign rd_beat      = mem[rd_ptr[AW-1:0]];
  assign m_axis.tvalid = avail;
  assign m_axis.tdata  = rd_beat.tdata;
  assign m_axis.tkeep  = rd_beat.tkeep;
  assign m_axis.tlast  = rd_beat.tlast;
  assign m_axis.tuser  = rd_beat.tuser;
endmodule

// File: tb/tb_axis_pkt_fifo.sv
// Bench for axis_pkt_fifo: instance 0 in beat mode, instance 1 in packet mode with error drop, both DEPTH=16.
// A queue-based reference model per instance predicts ready, valid, counts, drops and output beats every cycle.
module tb_axis_pkt_fifo;
  localparam int DEPTH = 16;
  localparam int CW    = 5;

  typedef logic [20:0] beat_v;  // {tdata[15:0], tkeep[1:0], tlast, tuser[1:0]}

  logic aclk = 1'b0;
  logic areset;
  always #5 aclk = ~aclk;

  logic [1:0]         s_vld;
  logic [1:0][15:0]   s_dat;
  logic [1:0][1:0]    s_keep;
  logic [1:0]         s_last;
  logic [1:0][1:0]    s_user;
  logic [1:0]         m_rdy;
  logic [1:0]         s_rdy;
  logic [1:0]         m_vld;
  logic [1:0][20:0]   m_beat;
  logic [1:0][CW-1:0] wr_cnt;
  logic [1:0][CW-1:0] rd_cnt;
  logic [1:0]         p_full;
  logic [1:0]         p_empty;
  logic [1:0]         p_drop;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : g_dut
    axis_pkt_fifo_if #(.DATA_W(16), .KEEP_W(2), .USER_W(2)) s_if ();
    axis_pkt_fifo_if #(.DATA_W(16), .KEEP_W(2), .USER_W(2)) m_if ();

    assign s_if.tvalid = s_vld[g];
    assign s_if.tdata  = s_dat[g];
    assign s_if.tkeep  = s_keep[g];
    assign s_if.tlast  = s_last[g];
    assign s_if.tuser  = s_user[g];
    assign m_if.tready = m_rdy[g];
    assign s_rdy[g]    = s_if.tready;
    assign m_vld[g]    = m_if.tvalid;
    assign m_beat[g]   = {m_if.tdata, m_if.tkeep, m_if.tlast, m_if.tuser};

    axis_pkt_fifo #(
      .DATA_W(16), .KEEP_W(2), .USER_W(2), .DEPTH(DEPTH),
      .PACKET_MODE(g), .DROP_ERR(g),
      .PROG_FULL_THRESH(8), .PROG_EMPTY_THRESH(2)
    ) u_dut (
      .aclk       (aclk),
      .areset     (areset),
      .s_axis     (s_if),
      .m_axis     (m_if),
      .wr_count   (wr_cnt[g]),
      .rd_count   (rd_cnt[g]),
      .prog_full  (p_full[g]),
      .prog_empty (p_empty[g]),
      .pkt_drop   (p_drop[g])
    );

    // Reference model: q = committed beats awaiting read, pend = current partial packet.
    beat_v q[$];
    beat_v pend[$];
    bit    live;
    bit    dropping;
    bit    drop_next;

    always @(negedge aclk) begin
      int    qn;
      int    tot;
      bit    exp_rdy;
      beat_v b;
      if (areset) begin
        q.delete();
        pend.delete();
        live      = 0;
        dropping  = 0;
        drop_next = 0;
      end else begin
        qn  = q.size();
        tot = qn + pend.size();
        exp_rdy = live && ((g == 0) ? (tot < DEPTH) : (dropping || tot < DEPTH || qn == 0));
        check($sformatf("i%0d_s_tready", g), s_rdy[g], exp_rdy);
        check($sformatf("i%0d_m_tvalid", g), m_vld[g], qn != 0);
        check($sformatf("i%0d_wr_count", g), wr_cnt[g], tot);
        check($sformatf("i%0d_rd_count", g), rd_cnt[g], qn);
        check($sformatf("i%0d_wr_le_depth", g), wr_cnt[g] <= DEPTH, 1);
        check($sformatf("i%0d_prog_full", g), p_full[g], tot >= 8);
        check($sformatf("i%0d_prog_empty", g), p_empty[g], qn <= 2);
        check($sformatf("i%0d_pkt_drop", g), p_drop[g], drop_next);
        drop_next = 0;
        if (m_vld[g] && m_rdy[g]) begin
          if (q.size() == 0) begin
            check($sformatf("i%0d_unexpected_out", g), 1, 0);
          end else begin
            b = q.pop_front();
            check($sformatf("i%0d_out_beat", g), m_beat[g], b);
          end
        end
        if (s_vld[g] && s_rdy[g]) begin
          b = {s_dat[g], s_keep[g], s_last[g], s_user[g]};
          if (g == 0) begin
            q.push_back(b);
          end else if (dropping) begin
            if (b[2]) dropping = 0;
          end else if (tot == DEPTH && qn == 0) begin
            pend.delete();
            drop_next = 1;
            dropping  = !b[2];
          end else if (b[2] && b[0]) begin
            pend.delete();
            drop_next = 1;
          end else begin
            pend.push_back(b);
            if (b[2]) begin
              while (pend.size() > 0) q.push_back(pend.pop_front());
            end
          end
        end
        live = 1;
      end
    end
  end

  // Observation trackers for the directed scenarios.
  beat_v cap1[$];
  int    drop_cnt1;
  int    rd_peak1;
  int    out_cnt0;

  always @(negedge aclk) begin
    if (!areset) begin
      if (m_vld[1] && m_rdy[1]) cap1.push_back(m_beat[1]);
      if (p_drop[1]) drop_cnt1++;
      if (int'(rd_cnt[1]) > rd_peak1) rd_peak1 = int'(rd_cnt[1]);
      if (m_vld[0] && m_rdy[0]) out_cnt0++;
    end
  end

  task automatic clear_trackers();
    cap1.delete();
    drop_cnt1 = 0;
    rd_peak1  = 0;
  endtask

  task automatic send_beat(input int g, input logic [15:0] d, input logic last,
                           input logic [1:0] user, output int waited);
    bit acc;
    s_dat[g]  = d;
    s_keep[g] = 2'b11;
    s_last[g] = last;
    s_user[g] = user;
    s_vld[g]  = 1'b1;
    waited = 0;
    acc    = 0;
    while (!acc && waited < 200) begin
      @(negedge aclk);
      acc = s_rdy[g];
      @(posedge aclk);
      #1;
      if (!acc) waited++;
    end
    if (!acc) check("send_timeout", 0, 1);
    s_vld[g] = 1'b0;
  endtask

  task automatic rand_drive(input int g, input int n_beats);
    int sent = 0;
    int cyc  = 0;
    int w;
    bit acc;
    while (sent < n_beats && cyc < 60000) begin
      @(negedge aclk);
      acc = s_vld[g] && s_rdy[g];
      @(posedge aclk);
      #1;
      cyc++;
      if (acc) sent++;
      if (acc || !s_vld[g]) begin
        s_vld[g]  = ($urandom % 2 == 1) && (sent < n_beats);
        s_dat[g]  = 16'($urandom);
        s_keep[g] = 2'($urandom);
        s_last[g] = (g == 1) ? ($urandom % 6 == 0) : 1'($urandom);
        s_user[g] = {1'($urandom), ($urandom % 8 == 0)};
      end
      m_rdy[g] = 1'($urandom);
    end
    s_vld[g] = 1'b0;
    check($sformatf("i%0d_rand_sent", g), sent, n_beats);
    m_rdy[g] = 1'b1;
    if (g == 1) send_beat(g, 16'h0, 1'b1, 2'b00, w);
  endtask

  task automatic check_reset_outputs(input string pfx);
    for (int g = 0; g < 2; g++) begin
      check($sformatf("%s_i%0d_m_tvalid", pfx, g), m_vld[g], 0);
      check($sformatf("%s_i%0d_s_tready", pfx, g), s_rdy[g], 0);
      check($sformatf("%s_i%0d_wr_count", pfx, g), wr_cnt[g], 0);
      check($sformatf("%s_i%0d_rd_count", pfx, g), rd_cnt[g], 0);
      check($sformatf("%s_i%0d_prog_full", pfx, g), p_full[g], 0);
      check($sformatf("%s_i%0d_prog_empty", pfx, g), p_empty[g], 1);
      check($sformatf("%s_i%0d_pkt_drop", pfx, g), p_drop[g], 0);
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    int maxw;
    logic [15:0] exp3 [5];
    areset = 1'b0;
    s_vld  = '0;
    s_dat  = '0;
    s_keep = '0;
    s_last = '0;
    s_user = '0;
    m_rdy  = '0;
    clear_trackers();
    out_cnt0 = 0;
    #1 areset = 1'b1;
    #3;
    check_reset_outputs("rst_init");
    repeat (3) @(posedge aclk);
    #1 areset = 1'b0;
    check("rst_rdy_held_low", s_rdy[0], 0);
    @(posedge aclk);
    #1;
    check("rst_rdy_rise", s_rdy[0], 1);

    // Beat mode: fill to full with reader stalled, then drain in order.
    for (int i = 0; i < 16; i++) send_beat(0, 16'(i), 1'b0, 2'b00, w);
    @(negedge aclk);
    check("t1_full_rdy", s_rdy[0], 0);
    check("t1_wr_count", wr_cnt[0], 16);
    check("t1_prog_full", p_full[0], 1);
    @(posedge aclk);
    #1 m_rdy[0] = 1'b1;
    for (int i = 0; i < 16; i++) begin
      @(negedge aclk);
      check("t1_out_vld", m_vld[0], 1);
      check("t1_out_dat", m_beat[0][20:5], i);
      @(posedge aclk);
      #1;
    end
    @(negedge aclk);
    check("t1_empty_vld", m_vld[0], 0);
    @(posedge aclk);
    #1;

    // Packet mode: nothing visible until tlast is accepted.
    m_rdy[1] = 1'b1;
    clear_trackers();
    for (int i = 0; i < 5; i++) begin
      send_beat(1, 16'(100 + i), i == 4, 2'b00, w);
      @(negedge aclk);
      check($sformatf("t2_vld_after_beat%0d", i + 1), m_vld[1], i == 4);
      @(posedge aclk);
      #1;
    end
    repeat (8) @(posedge aclk);
    #1;
    check("t2_out_cnt", cap1.size(), 5);
    foreach (cap1[i]) begin
      check("t2_out_dat", cap1[i][20:5], 100 + i);
      check("t2_out_last", cap1[i][2], i == 4);
    end

    // Errored packet B between A and C is dropped.
    m_rdy[1] = 1'b0;
    clear_trackers();
    for (int i = 0; i < 3; i++) send_beat(1, 16'(200 + i), i == 2, 2'b00, w);
    for (int i = 0; i < 4; i++) send_beat(1, 16'(210 + i), i == 3, (i == 3) ? 2'b01 : 2'b00, w);
    for (int i = 0; i < 2; i++) send_beat(1, 16'(220 + i), i == 1, 2'b00, w);
    repeat (3) @(posedge aclk);
    #1;
    check("t3_rd_count", rd_cnt[1], 5);
    check("t3_rd_peak", rd_peak1, 5);
    check("t3_drop_cnt", drop_cnt1, 1);
    m_rdy[1] = 1'b1;
    repeat (10) @(posedge aclk);
    #1;
    exp3 = '{16'd200, 16'd201, 16'd202, 16'd220, 16'd221};
    check("t3_out_cnt", cap1.size(), 5);
    foreach (cap1[i]) if (i < 5) check("t3_out_dat", cap1[i][20:5], exp3[i]);

    // Oversize packet is swallowed whole; the next packet passes.
    clear_trackers();
    maxw = 0;
    for (int i = 0; i < 20; i++) begin
      send_beat(1, 16'(300 + i), i == 19, 2'b00, w);
      if (w > maxw) maxw = w;
    end
    for (int i = 0; i < 3; i++) begin
      send_beat(1, 16'(400 + i), i == 2, 2'b00, w);
      if (w > maxw) maxw = w;
    end
    repeat (8) @(posedge aclk);
    #1;
    check("t4_rdy_held", maxw, 0);
    check("t4_drop_cnt", drop_cnt1, 1);
    check("t4_out_cnt", cap1.size(), 3);
    foreach (cap1[i]) check("t4_out_dat", cap1[i][20:5], 400 + i);

    // Random valid/ready on both instances with pointer wrap.
    out_cnt0 = 0;
    fork
      rand_drive(0, 10000);
      rand_drive(1, 4000);
    join
    m_rdy = 2'b11;
    repeat (40) @(posedge aclk);
    #1;
    check("t5_i0_drained", rd_cnt[0], 0);
    check("t5_i1_drained", rd_cnt[1], 0);
    check("t5_i0_out_cnt", out_cnt0, 10000);

    // Reset mid-packet with 7 beats stored.
    m_rdy[1] = 1'b0;
    for (int i = 0; i < 7; i++) send_beat(1, 16'(500 + i), 1'b0, 2'b00, w);
    @(negedge aclk);
    check("t6_stored", wr_cnt[1], 7);
    @(posedge aclk);
    #2 areset = 1'b1;
    #1;
    check_reset_outputs("t6_rst");
    repeat (2) @(posedge aclk);
    #1 areset = 1'b0;
    @(posedge aclk);
    #1;
    check("t6_rdy_rise", s_rdy[1], 1);
    m_rdy[1] = 1'b1;
    clear_trackers();
    for (int i = 0; i < 4; i++) send_beat(1, 16'(600 + i), i == 3, 2'b00, w);
    repeat (8) @(posedge aclk);
    #1;
    check("t6_out_cnt", cap1.size(), 4);
    check("t6_drop_cnt", drop_cnt1, 0);
    foreach (cap1[i]) begin
      check("t6_out_dat", cap1[i][20:5], 600 + i);
      check("t6_out_last", cap1[i][2], i == 3);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
